bus_cmd_master: RTL and testbench



---
 rtl/bus_cmd_pkg.sv | 19 +
 rtl/bus_cmd_master_if.sv | 24 ++
 rtl/bus_cmd_master.sv | 228 ++++++++++++++++++++++
 tb/tb_bus_cmd_master.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cmd_pkg.sv
// Shared constants and state encoding for the byte-stream bus initiator.
package bus_cmd_pkg;

  localparam logic [3:0] CMD_WRITE = 4'h1;
  localparam logic [3:0] CMD_READ  = 4'h2;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    BUS_WR = 3'd3,
    BUS_RD = 3'd4,
    RSP    = 3'd5
  } state_t;

endpackage

// File: rtl/bus_cmd_master_if.sv
// Command/response byte streams plus the single-word peripheral bus,
// seen from the initiator (master) and from the bench/peripheral side (slave).
interface bus_cmd_master_if;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  Write;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;

  modport master (
    input  cmd_data, cmd_valid, rsp_ready, RData,
    output cmd_ready, rsp_data, rsp_valid, Write, Addr, WData
  );

  modport slave (
    output cmd_data, cmd_valid, rsp_ready, RData,
    input  cmd_ready, rsp_data, rsp_valid, Write, Addr, WData
  );
endinterface

// File: rtl/bus_cmd_master.sv
// Decodes framed command bytes into one peripheral bus transaction each and
// streams back an ACK/ERR byte or the four read-data bytes.
module bus_cmd_master
  import bus_cmd_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  bus_cmd_master_if.master bus,
  output logic             busy
);

  localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t            state, state_nx;
  logic [1:0]        idx, idx_nx;
  logic [LAT_W-1:0]  lat_cnt, lat_nx;
  logic [TO_W-1:0]   to_cnt, to_nx;
  logic              is_write, is_write_nx;
  logic [3:0]        mask, mask_nx;
  logic [31:0]       addr_sh, addr_sh_nx;
  logic [31:0]       data_sh, data_sh_nx;
  logic [23:0]       rsp_buf, rsp_buf_nx;
  logic [1:0]        rsp_left, rsp_left_nx;
  logic [3:0]        write_nx;
  logic [31:0]       addr_nx, wdata_nx;
  logic [7:0]        rsp_data_nx;
  logic              rsp_valid_nx;
  logic              busy_nx;

  logic              cmd_fire, rsp_fire, to_expired;
  logic [TO_W-1:0]   to_count;
  logic [31:0]       addr_shift, data_shift;

  assign bus.cmd_ready = !rst && (state == IDLE || state == ADDR || state == DATA);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
  // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
  assign addr_shift    = {bus.cmd_data, addr_sh[31:8]};
  assign data_shift    = {bus.cmd_data, data_sh[31:8]};
  assign to_expired    = TO_EN && (to_cnt == TO_LAST);
  assign to_count      = TO_EN ? (to_cnt + TO_W'(1)) : to_cnt;

  // Next-state and next-output decode.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    lat_nx       = lat_cnt;
    to_nx        = to_cnt;
    is_write_nx  = is_write;
    mask_nx      = mask;
    addr_sh_nx   = addr_sh;
    data_sh_nx   = data_sh;
    rsp_buf_nx   = rsp_buf;
    rsp_left_nx  = rsp_left;
    write_nx     = 4'h0;
    addr_nx      = bus.Addr;
    wdata_nx     = bus.WData;
    rsp_data_nx  = bus.rsp_data;
    rsp_valid_nx = bus.rsp_valid;

    case (state)
      IDLE: begin
        idx_nx = 2'd0;
        lat_nx = '0;
        to_nx  = '0;
        if (cmd_fire) begin
          case (bus.cmd_data[7:4])
            CMD_WRITE: begin
              state_nx    = ADDR;
              is_write_nx = 1'b1;
              mask_nx     = bus.cmd_data[3:0];
            end
            CMD_READ: begin
              state_nx    = ADDR;
              is_write_nx = 1'b0;
              mask_nx     = 4'h0;
            end
            default: begin
              state_nx     = RSP;
              rsp_valid_nx = 1'b1;
              rsp_data_nx  = RSP_ERR;
              rsp_left_nx  = 2'd0;
            end
          endcase
        end else begin
          state_nx = IDLE;
        end
      end

      ADDR: begin
        if (cmd_fire) begin
          to_nx      = '0;
          addr_sh_nx = addr_shift;
          idx_nx     = idx + 2'd1;
          if (idx == 2'd3) begin
            if (is_write) begin
              state_nx = DATA;
            end else begin
              state_nx = BUS_RD;
              addr_nx  = addr_shift;
              lat_nx   = '0;
            end
          end else begin
            state_nx = ADDR;
          end
        end else if (to_expired) begin
          state_nx = IDLE;
        end else begin
          to_nx = to_count;
        end
      end

      DATA: begin
        if (cmd_fire) begin
          to_nx      = '0;
          data_sh_nx = data_shift;
          idx_nx     = idx + 2'd1;
          if (idx == 2'd3) begin
            state_nx = BUS_WR;
            addr_nx  = addr_sh;
            wdata_nx = data_shift;
            write_nx = mask;
          end else begin
            state_nx = DATA;
          end
        end else if (to_expired) begin
          state_nx = IDLE;
        end else begin
          to_nx = to_count;
        end
      end

      BUS_WR: begin
        state_nx     = RSP;
        rsp_valid_nx = 1'b1;
        rsp_data_nx  = RSP_ACK;
        rsp_left_nx  = 2'd0;
      end

      BUS_RD: begin
        if (lat_cnt == LAT_LAST) begin
          state_nx     = RSP;
          rsp_valid_nx = 1'b1;
          rsp_data_nx  = bus.RData[7:0];
          rsp_buf_nx   = bus.RData[31:8];
          rsp_left_nx  = 2'd3;
        end else begin
          lat_nx = lat_cnt + LAT_W'(1);
        end
      end

      RSP: begin
        if (rsp_fire) begin
          if (rsp_left == 2'd0) begin
            state_nx     = IDLE;
            rsp_valid_nx = 1'b0;
          end else begin
            rsp_data_nx = rsp_buf[7:0];
            rsp_buf_nx  = {8'h00, rsp_buf[23:8]};
            rsp_left_nx = rsp_left - 2'd1;
          end
        end else begin
          state_nx = RSP;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counters, shadow registers and registered bus/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= 2'd0;
      lat_cnt       <= '0;
      to_cnt        <= '0;
      is_write      <= 1'b0;
      mask          <= 4'h0;
      addr_sh       <= 32'h0;
      data_sh       <= 32'h0;
      rsp_buf       <= 24'h0;
      rsp_left      <= 2'd0;
      bus.Write     <= 4'h0;
      bus.Addr      <= 32'h0;
      bus.WData     <= 32'h0;
      bus.rsp_data  <= 8'h00;
      bus.rsp_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      idx           <= idx_nx;
      lat_cnt       <= lat_nx;
      to_cnt        <= to_nx;
      is_write      <= is_write_nx;
      mask          <= mask_nx;
      addr_sh       <= addr_sh_nx;
      data_sh       <= data_sh_nx;
      rsp_buf       <= rsp_buf_nx;
      rsp_left      <= rsp_left_nx;
      bus.Write     <= write_nx;
      bus.Addr      <= addr_nx;
      bus.WData     <= wdata_nx;
      bus.rsp_data  <= rsp_data_nx;
      bus.rsp_valid <= rsp_valid_nx;
      busy          <= busy_nx;
    end
  end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed scoreboard bench: dut0 (READ_LATENCY=0) and dut1 (READ_LATENCY=1),
// both with TIMEOUT_CYCLES=16, driven one at a time through a shared stream.
module tb_bus_cmd_master;
  import bus_cmd_pkg::*;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] cmd_data  = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       rsp_ready = 1'b1;
  logic       sel       = 1'b0;
  logic       busy0, busy1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  logic [7:0] exp_q[$];

  bus_cmd_master_if if0();
  bus_cmd_master_if if1();

  assign if0.cmd_data  = cmd_data;
  assign if0.cmd_valid = cmd_valid && !sel;
  assign if0.rsp_ready = rsp_ready;
  assign if1.cmd_data  = cmd_data;
  assign if1.cmd_valid = cmd_valid && sel;
  assign if1.rsp_ready = rsp_ready;

  bus_cmd_master #(.READ_LATENCY(0), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master), .busy(busy0));
  bus_cmd_master #(.READ_LATENCY(1), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        s_ready, s_rsp_valid, s_busy;
  logic [7:0]  s_rsp_data;
  logic [3:0]  s_write;
  logic [31:0] s_addr, s_wdata;
  assign s_ready     = sel ? if1.cmd_ready : if0.cmd_ready;
  assign s_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
  assign s_rsp_data  = sel ? if1.rsp_data  : if0.rsp_data;
  assign s_busy      = sel ? busy1         : busy0;
  assign s_write     = sel ? if1.Write     : if0.Write;
  assign s_addr      = sel ? if1.Addr      : if0.Addr;
  assign s_wdata     = sel ? if1.WData     : if0.WData;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_0008: return 32'h1234_5678;
      32'h0000_0010: return 32'hCAFE_F00D;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Responders: data is valid only in the cycle matching the read latency
  // after Addr changes, junk otherwise, so a mistimed sample is visible.
  logic [31:0] prev_addr0, prev_addr1;
  logic [1:0]  age0 = 2'd3, age1 = 2'd3;
  logic        fresh0, fresh1;
  assign fresh0 = (if0.Addr != prev_addr0);
  assign fresh1 = (if1.Addr != prev_addr1);
  always @(posedge clk) begin
    prev_addr0 <= if0.Addr;
    prev_addr1 <= if1.Addr;
    age0 <= fresh0 ? 2'd1 : ((age0 == 2'd3) ? 2'd3 : age0 + 2'd1);
    age1 <= fresh1 ? 2'd1 : ((age1 == 2'd3) ? 2'd3 : age1 + 2'd1);
  end
  assign if0.RData = (fresh0)                  ? mem_f(if0.Addr) : 32'hBAD0_BAD0;
  assign if1.RData = (!fresh1 && age1 == 2'd1) ? mem_f(if1.Addr) : 32'hBAD1_BAD1;

  // Bus monitor on the selected DUT.
  int          wr_cnt = 0, b2b = 0, last_wr_cyc = 0;
  logic [3:0]  last_mask = 4'h0, prev_wr = 4'h0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  always @(negedge clk) begin
    prev_wr <= s_write;
    if (s_write != 4'h0) begin
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
      last_mask   <= s_write;
      last_addr   <= s_addr;
      last_wdata  <= s_wdata;
      if (prev_wr != 4'h0) b2b <= b2b + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    #1;
    while (!s_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("cmd_ready_wait", 32'(s_ready), 32'h1);
    last_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] d, input bit with_data);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (with_data) begin
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    end
  endtask

  task automatic get_rsp(input string tag, output int at);
    int n;
    bit got;
    logic [7:0] e;
    n   = 0;
    got = 1'b0;
    at  = -1;
    #1;
    while (!got && n < 200) begin
      if (s_rsp_valid && rsp_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        chk(tag, 32'(s_rsp_data), 32'(e));
        at  = cyc;
        got = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    if (!got) chk({tag, "_timeout"}, 32'(got), 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, at, rv, stall_bad, n;
    logic [7:0] held;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_write",     32'(s_write),     32'h0);
    chk("rst_addr",      s_addr,           32'h0);
    chk("rst_wdata",     s_wdata,          32'h0);
    chk("rst_rsp_valid", 32'(s_rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(s_rsp_data),  32'h0);
    chk("rst_busy",      32'(s_busy),      32'h0);
    chk("rst_cmd_ready", 32'(s_ready),     32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(s_ready), 32'h1);

    // Full-mask write
    exp_q.push_back(RSP_ACK);
    n0 = wr_cnt;
    send_cmd(8'h1F, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1);
    chk("wr_strobe_n1", 32'(s_write), 32'hF);
    get_rsp("wr_ack", at);
    chk("wr_rsp_lat",  32'(at),          32'(last_acc + 2));
    chk("wr_busy_end", 32'(s_busy),      32'h0);
    chk("wr_count",    32'(wr_cnt - n0), 32'h1);
    chk("wr_mask",     32'(last_mask),   32'hF);
    chk("wr_addr",     last_addr,        32'h0000_0004);
    chk("wr_wdata",    last_wdata,       32'hDEAD_BEEF);
    chk("wr_cyc",      32'(last_wr_cyc), 32'(last_acc + 1));

    // Read, latency 0
    push_word(mem_f(32'h0000_0008));
    n0 = wr_cnt;
    send_cmd(8'h20, 32'h0000_0008, 32'h0, 1'b0);
    chk("rd_addr_n1",  s_addr,           32'h0000_0008);
    chk("rd_write_0",  32'(s_write),     32'h0);
    get_rsp("rd_b0", at);
    chk("rd_rsp_lat",  32'(at),          32'(last_acc + 2));
    get_rsp("rd_b1", at);
    get_rsp("rd_b2", at);
    get_rsp("rd_b3", at);
    chk("rd_no_write", 32'(wr_cnt - n0), 32'h0);

    // Partial mask and empty mask
    exp_q.push_back(RSP_ACK);
    n0 = wr_cnt;
    send_cmd(8'h13, 32'h0000_0100, 32'h0000_ABCD, 1'b1);
    chk("m3_strobe", 32'(s_write), 32'h3);
    get_rsp("m3_ack", at);
    chk("m3_count",  32'(wr_cnt - n0), 32'h1);
    chk("m3_addr",   last_addr,        32'h0000_0100);
    exp_q.push_back(RSP_ACK);
    n0 = wr_cnt;
    send_cmd(8'h10, 32'h0000_0104, 32'h1111_2222, 1'b1);
    chk("m0_strobe", 32'(s_write), 32'h0);
    get_rsp("m0_ack", at);
    chk("m0_count",  32'(wr_cnt - n0), 32'h0);

    // Illegal opcode then a good read
    exp_q.push_back(RSP_ERR);
    n0 = wr_cnt;
    send_byte(8'h70);
    get_rsp("err_rsp", at);
    chk("err_busy",  32'(s_busy),      32'h0);
    push_word(mem_f(32'h0000_0010));
    send_cmd(8'h20, 32'h0000_0010, 32'h0, 1'b0);
    get_rsp("rd2_b0", at);
    get_rsp("rd2_b1", at);
    get_rsp("rd2_b2", at);
    get_rsp("rd2_b3", at);
    chk("err_no_write", 32'(wr_cnt - n0), 32'h0);

    // Timeout of a partial frame
    n0 = wr_cnt;
    send_byte(8'h1F);
    send_byte(8'h11);
    send_byte(8'h22);
    rv = 0;
    repeat (15) begin
      @(negedge clk);
      if (s_rsp_valid) rv++;
    end
    chk("to_busy_15", 32'(s_busy), 32'h1);
    @(negedge clk);
    chk("to_busy_16", 32'(s_busy), 32'h0);
    chk("to_no_rsp",  32'(rv + int'(s_rsp_valid)), 32'h0);
    chk("to_no_bus",  32'(wr_cnt - n0), 32'h0);
    chk("to_addr",    s_addr, 32'h0000_0010);
    exp_q.push_back(RSP_ACK);
    send_cmd(8'h1F, 32'h0000_0020, 32'h0102_0304, 1'b1);
    get_rsp("to_new_ack", at);
    chk("to_new_count", 32'(wr_cnt - n0), 32'h1);
    chk("to_new_addr",  last_addr,  32'h0000_0020);
    chk("to_new_wdata", last_wdata, 32'h0102_0304);

    // Response backpressure
    rsp_ready = 1'b0;
    push_word(mem_f(32'h0000_0008));
    n0 = wr_cnt;
    send_cmd(8'h20, 32'h0000_0008, 32'h0, 1'b0);
    n = 0;
    while (!s_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(s_rsp_valid), 32'h1);
    held = s_rsp_data;
    stall_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_rsp_data !== held || s_rsp_valid !== 1'b1 || s_ready !== 1'b0) stall_bad++;
    end
    chk("bp_stable", 32'(stall_bad), 32'h0);
    chk("bp_no_bus", 32'(wr_cnt - n0), 32'h0);
    chk("bp_addr",   s_addr, 32'h0000_0008);
    rsp_ready = 1'b1;
    get_rsp("bp_b0", at);
    get_rsp("bp_b1", at);
    get_rsp("bp_b2", at);
    get_rsp("bp_b3", at);

    // Reset in the middle of the data bytes
    n0 = wr_cnt;
    send_byte(8'h1F);
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
    send_byte(8'h99);
    send_byte(8'h98);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", 32'(s_ready), 32'h0);
    @(negedge clk);
    chk("mid_rst_write", 32'(s_write),     32'h0);
    chk("mid_rst_addr",  s_addr,           32'h0);
    chk("mid_rst_wdata", s_wdata,          32'h0);
    chk("mid_rst_rspv",  32'(s_rsp_valid), 32'h0);
    chk("mid_rst_rspd",  32'(s_rsp_data),  32'h0);
    chk("mid_rst_busy",  32'(s_busy),      32'h0);
    rst = 1'b0;
    chk("mid_rst_no_bus", 32'(wr_cnt - n0), 32'h0);

    // Reset while the write strobe is high
    n0 = wr_cnt;
    send_cmd(8'h1F, 32'h0000_0044, 32'h5566_7788, 1'b1);
    chk("cut_strobe", 32'(s_write), 32'hF);
    rst = 1'b1;
    @(negedge clk);
    chk("cut_write", 32'(s_write),     32'h0);
    chk("cut_rspv",  32'(s_rsp_valid), 32'h0);
    rst = 1'b0;
    rv = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_rsp_valid) rv++;
    end
    chk("cut_no_rsp", 32'(rv), 32'h0);
    chk("cut_count",  32'(wr_cnt - n0), 32'h1);

    // Read, latency 1
    sel = 1'b1;
    @(negedge clk);
    push_word(mem_f(32'h0000_0008));
    n0 = wr_cnt;
    send_cmd(8'h20, 32'h0000_0008, 32'h0, 1'b0);
    chk("l1_addr_n1", s_addr, 32'h0000_0008);
    get_rsp("l1_b0", at);
    chk("l1_rsp_lat", 32'(at), 32'(last_acc + 3));
    get_rsp("l1_b1", at);
    get_rsp("l1_b2", at);
    get_rsp("l1_b3", at);
    push_word(mem_f(32'h0000_0010));
    send_cmd(8'h2F, 32'h0000_0010, 32'h0, 1'b0);
    get_rsp("l1m_b0", at);
    get_rsp("l1m_b1", at);
    get_rsp("l1m_b2", at);
    get_rsp("l1m_b3", at);
    chk("l1_no_write", 32'(wr_cnt - n0), 32'h0);

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    chk("no_b2b",   32'(b2b),          32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
